// File: rtl/pe_bypass_hist.sv
// pe_bypass_hist: PE operand bypass network with WB history and a registered ID operand stage.
// Define PE_BYPASS_NEIGHBOUR_EN to add the neighbour/CP operand-A select and oPE_Port1_Data.
module pe_bypass_hist #(
    parameter  int DATA_WIDTH     = 32,
    parameter  int RF_INDEX_WIDTH = 5,
    parameter  int HIST_DEPTH     = 2,
    parameter  int NUM_EX_SRC     = 4,
    localparam int SEL_W          = $clog2(NUM_EX_SRC)
) (
    input  logic                             iClk,
    input  logic                             iReset_n,
    input  logic                             iStall,
    input  logic                             iFlush,
    input  logic                             iIssue_Valid,
    input  logic                             iWB_Write_En,
    input  logic [RF_INDEX_WIDTH-1:0]        iWB_Write_Addr,
    input  logic [DATA_WIDTH-1:0]            iWB_Write_Data,
    input  logic [RF_INDEX_WIDTH-1:0]        iRd_Addr_A,
    input  logic [RF_INDEX_WIDTH-1:0]        iRd_Addr_B,
    input  logic                             iBypass_A,
    input  logic                             iBypass_B,
    input  logic [SEL_W-1:0]                 iBypass_Sel_A,
    input  logic [SEL_W-1:0]                 iBypass_Sel_B,
    input  logic [NUM_EX_SRC*DATA_WIDTH-1:0] iEX_Data,
    input  logic [DATA_WIDTH-1:0]            iRF_Data_A,
    input  logic [DATA_WIDTH-1:0]            iRF_Data_B,
    input  logic                             iSelect_Imm,
    input  logic [DATA_WIDTH-1:0]            iImmediate,
    input  logic                             iIs_SUB,
`ifdef PE_BYPASS_NEIGHBOUR_EN
    input  logic [2:0]                       iData_Selection,
    input  logic [DATA_WIDTH-1:0]            iLeft_PE_Port1_Data,
    input  logic [DATA_WIDTH-1:0]            iLeft_PE_Port1_Minus4_Data,
    input  logic [DATA_WIDTH-1:0]            iRight_PE_Port1_Data,
    input  logic [DATA_WIDTH-1:0]            iRight_PE_Port1_Plus4_Data,
    input  logic [DATA_WIDTH-1:0]            iCP_Data,
    output logic [DATA_WIDTH-1:0]            oPE_Port1_Data,
`endif
    output logic [DATA_WIDTH-1:0]            oOperand_A,
    output logic [DATA_WIDTH-1:0]            oOperand_B,
    output logic [DATA_WIDTH-1:0]            oStore_Data,
    output logic                             oOperand_Valid,
    output logic                             oHist_Hit_A,
    output logic                             oHist_Hit_B
);

    logic [HIST_DEPTH-1:0]                     r_hist_vld;
    logic [HIST_DEPTH-1:0][RF_INDEX_WIDTH-1:0] r_hist_addr;
    logic [HIST_DEPTH-1:0][DATA_WIDTH-1:0]     r_hist_data;

    logic [DATA_WIDTH:0]   w_res_a;
    logic [DATA_WIDTH:0]   w_res_b;
    logic [DATA_WIDTH-1:0] w_base_a;
    logic [DATA_WIDTH-1:0] w_base_b;
    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_b_sel;
    logic [DATA_WIDTH-1:0] w_fin_a;
    logic [DATA_WIDTH-1:0] w_fin_b;
    logic                  w_rsubi;

    // Returns {from_history, data}; EX bypass > current WB > history (youngest first) > RF.
    function automatic logic [DATA_WIDTH:0] f_resolve(
        input logic [RF_INDEX_WIDTH-1:0]             addr,
        input logic                                  byp,
        input logic [SEL_W-1:0]                      sel,
        input logic [DATA_WIDTH-1:0]                 rf,
        input logic [NUM_EX_SRC*DATA_WIDTH-1:0]      ex,
        input logic                                  wb_en,
        input logic [RF_INDEX_WIDTH-1:0]             wb_addr,
        input logic [DATA_WIDTH-1:0]                 wb_data,
        input logic [HIST_DEPTH-1:0]                 hv,
        input logic [HIST_DEPTH-1:0][RF_INDEX_WIDTH-1:0] ha,
        input logic [HIST_DEPTH-1:0][DATA_WIDTH-1:0] hd
    );
        logic [DATA_WIDTH-1:0] w_ex;
        logic [DATA_WIDTH:0]   w_res;
        logic                  w_fwd;
        // Out-of-range selects fall back to source 0.
        w_ex = ex[DATA_WIDTH-1:0];
        for (int k = 1; k < NUM_EX_SRC; k++) begin
            if (sel == SEL_W'(k)) w_ex = ex[k*DATA_WIDTH +: DATA_WIDTH];
        end
        // r0/r1 always come from the RF.
        w_fwd = (addr > RF_INDEX_WIDTH'(1));
        w_res = {1'b0, rf};
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (hv[k] && (ha[k] == addr) && w_fwd) w_res = {1'b1, hd[k]};
        end
        if (wb_en && (wb_addr == addr) && w_fwd) w_res = {1'b0, wb_data};
        if (byp) w_res = {1'b0, w_ex};
        return w_res;
    endfunction

    assign w_res_a = f_resolve(iRd_Addr_A, iBypass_A, iBypass_Sel_A, iRF_Data_A,
                               iEX_Data, iWB_Write_En, iWB_Write_Addr,
                               iWB_Write_Data, r_hist_vld, r_hist_addr,
                               r_hist_data);
    assign w_res_b = f_resolve(iRd_Addr_B, iBypass_B, iBypass_Sel_B, iRF_Data_B,
                               iEX_Data, iWB_Write_En, iWB_Write_Addr,
                               iWB_Write_Data, r_hist_vld, r_hist_addr,
                               r_hist_data);

    assign w_base_a = w_res_a[DATA_WIDTH-1:0];
    assign w_base_b = w_res_b[DATA_WIDTH-1:0];

`ifdef PE_BYPASS_NEIGHBOUR_EN
    // Operand A from a neighbour PE or the CP, else the resolved local value.
    always_comb begin
        w_op_a = w_base_a;
        case (iData_Selection)
            3'b010:  w_op_a = iLeft_PE_Port1_Data;
            3'b001:  w_op_a = iRight_PE_Port1_Data;
            3'b011:  w_op_a = iCP_Data;
            3'b110:  w_op_a = iLeft_PE_Port1_Minus4_Data;
            3'b101:  w_op_a = iRight_PE_Port1_Plus4_Data;
            default: w_op_a = w_base_a;
        endcase
    end

    assign oPE_Port1_Data = w_base_a;
`else
    assign w_op_a = w_base_a;
`endif

    // RSUBI computes imm - rs, so the immediate moves onto A.
    assign w_rsubi = iIs_SUB & iSelect_Imm;
    assign w_b_sel = iSelect_Imm ? iImmediate : w_base_b;
    assign w_fin_a = w_rsubi ? w_b_sel : w_op_a;
    assign w_fin_b = w_rsubi ? w_op_a : w_b_sel;

    // WB history shift register; keeps moving through stalls and flushes.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            r_hist_vld  <= '0;
            r_hist_addr <= '0;
            r_hist_data <= '0;
        end else if (iWB_Write_En) begin
            r_hist_vld[0]  <= 1'b1;
            r_hist_addr[0] <= iWB_Write_Addr;
            r_hist_data[0] <= iWB_Write_Data;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                r_hist_vld[k]  <= r_hist_vld[k-1];
                r_hist_addr[k] <= r_hist_addr[k-1];
                r_hist_data[k] <= r_hist_data[k-1];
            end
        end
    end

    // Operand output stage: reset > flush > stall > capture.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            oOperand_A     <= '0;
            oOperand_B     <= '0;
            oStore_Data    <= '0;
            oOperand_Valid <= 1'b0;
            oHist_Hit_A    <= 1'b0;
            oHist_Hit_B    <= 1'b0;
        end else if (iFlush) begin
            oOperand_Valid <= 1'b0;
        end else if (!iStall) begin
            oOperand_A     <= w_fin_a;
            oOperand_B     <= w_fin_b;
            oStore_Data    <= w_base_b;
            oOperand_Valid <= iIssue_Valid;
            oHist_Hit_A    <= w_res_a[DATA_WIDTH];
            oHist_Hit_B    <= w_res_b[DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_pe_bypass_hist.sv
// tb_pe_bypass_hist: directed bench for pe_bypass_hist with a queue-based reference model.
// Model checks every cycle; literal checks pin the directed scenarios.
module tb_pe_bypass_hist;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        issue;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rd_a;
    logic [4:0]  rd_b;
    logic        byp_a;
    logic        byp_b;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;
    logic [127:0] ex;
    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic        sel_imm;
    logic [31:0] imm;
    logic        is_sub;
`ifdef PE_BYPASS_NEIGHBOUR_EN
    logic [2:0]  dsel;
    logic [31:0] left_d;
    logic [31:0] left_m4;
    logic [31:0] right_d;
    logic [31:0] right_p4;
    logic [31:0] cp_d;
    logic [31:0] port1;
`endif
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [31:0] o_s;
    logic        o_v;
    logic        o_ha;
    logic        o_hb;

    int passed = 0;
    int total  = 0;
    logic chk_en = 1'b0;

    pe_bypass_hist dut (
        .iClk           (clk),
        .iReset_n       (rst_n),
        .iStall         (stall),
        .iFlush         (flush),
        .iIssue_Valid   (issue),
        .iWB_Write_En   (wb_en),
        .iWB_Write_Addr (wb_addr),
        .iWB_Write_Data (wb_data),
        .iRd_Addr_A     (rd_a),
        .iRd_Addr_B     (rd_b),
        .iBypass_A      (byp_a),
        .iBypass_B      (byp_b),
        .iBypass_Sel_A  (sel_a),
        .iBypass_Sel_B  (sel_b),
        .iEX_Data       (ex),
        .iRF_Data_A     (rf_a),
        .iRF_Data_B     (rf_b),
        .iSelect_Imm    (sel_imm),
        .iImmediate     (imm),
        .iIs_SUB        (is_sub),
`ifdef PE_BYPASS_NEIGHBOUR_EN
        .iData_Selection            (dsel),
        .iLeft_PE_Port1_Data        (left_d),
        .iLeft_PE_Port1_Minus4_Data (left_m4),
        .iRight_PE_Port1_Data       (right_d),
        .iRight_PE_Port1_Plus4_Data (right_p4),
        .iCP_Data                   (cp_d),
        .oPE_Port1_Data             (port1),
`endif
        .oOperand_A     (o_a),
        .oOperand_B     (o_b),
        .oStore_Data    (o_s),
        .oOperand_Valid (o_v),
        .oHist_Hit_A    (o_ha),
        .oHist_Hit_B    (o_hb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        else
            passed++;
    endtask

    // Reference model: WB history as a youngest-first queue.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;

    wb_t hq[$];

    logic [31:0] e_a = '0;
    logic [31:0] e_b = '0;
    logic [31:0] e_s = '0;
    logic        e_v = 1'b0;
    logic        e_ha = 1'b0;
    logic        e_hb = 1'b0;

    function automatic logic [32:0] m_res(input logic [4:0] a, input logic byp,
                                          input logic [1:0] sel,
                                          input logic [31:0] rf);
        int idx;
        if (byp) begin
            idx = (int'(sel) < 4) ? int'(sel) : 0;
            return {1'b0, ex[idx*32 +: 32]};
        end
        if (a > 5'd1 && wb_en && wb_addr == a) return {1'b0, wb_data};
        if (a > 5'd1) begin
            foreach (hq[i]) if (hq[i].a == a) return {1'b1, hq[i].d};
        end
        return {1'b0, rf};
    endfunction

    always @(posedge clk) begin : model
        logic [32:0] ra;
        logic [32:0] rb;
        logic [31:0] a;
        logic [31:0] b;
        if (!rst_n) begin
            e_a = '0; e_b = '0; e_s = '0;
            e_v = 1'b0; e_ha = 1'b0; e_hb = 1'b0;
            hq.delete();
        end else begin
            if (flush) begin
                e_v = 1'b0;
            end else if (!stall) begin
                ra = m_res(rd_a, byp_a, sel_a, rf_a);
                rb = m_res(rd_b, byp_b, sel_b, rf_b);
                a = ra[31:0];
`ifdef PE_BYPASS_NEIGHBOUR_EN
                if (dsel == 3'b010) a = left_d;
                else if (dsel == 3'b001) a = right_d;
                else if (dsel == 3'b011) a = cp_d;
                else if (dsel == 3'b110) a = left_m4;
                else if (dsel == 3'b101) a = right_p4;
`endif
                b = sel_imm ? imm : rb[31:0];
                if (is_sub && sel_imm) begin
                    e_a = b; e_b = a;
                end else begin
                    e_a = a; e_b = b;
                end
                e_s  = rb[31:0];
                e_ha = ra[32];
                e_hb = rb[32];
                e_v  = issue;
            end
            if (wb_en) begin
                hq.push_front({wb_addr, wb_data});
                if (hq.size() > 2) void'(hq.pop_back());
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("mdl_opA", o_a, e_a);
            check("mdl_opB", o_b, e_b);
            check("mdl_store", o_s, e_s);
            check("mdl_valid", 32'(o_v), 32'(e_v));
            check("mdl_hitA", 32'(o_ha), 32'(e_ha));
            check("mdl_hitB", 32'(o_hb), 32'(e_hb));
        end
    end

    task automatic clr();
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; issue = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        rd_a = '0; rd_b = '0; byp_a = 1'b0; byp_b = 1'b0;
        sel_a = '0; sel_b = '0;
        ex = {32'h0000_0055, 32'h0000_0044, 32'h0000_0033, 32'h0000_0010};
        rf_a = '0; rf_b = '0; sel_imm = 1'b0; imm = '0; is_sub = 1'b0;
`ifdef PE_BYPASS_NEIGHBOUR_EN
        dsel = '0; left_d = 32'h1111; left_m4 = 32'hBEEF;
        right_d = 32'h2222; right_p4 = 32'h3333; cp_d = 32'h4444;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // T1 reset, asserted over stall/flush and a WB write
        clr();
        rst_n = 1'b0; stall = 1'b1; flush = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD; rf_a = 32'h99;
        repeat (2) @(posedge clk);
        #1;
        check("rst_opA", o_a, 32'h0);
        check("rst_store", o_s, 32'h0);
        check("rst_valid", 32'(o_v), 32'h0);
        @(negedge clk);
        clr(); chk_en = 1'b1;
        rd_a = 5'd5; rf_a = 32'h1234;
        tick();
        check("t1_rf_after_rst", o_a, 32'h1234);
        check("t1_hitA", 32'(o_ha), 32'h0);
        check("t1_valid", 32'(o_v), 32'h1);

        // T2 priority
        @(negedge clk); clr(); issue = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h22;
        tick();
        check("t2_issue0_valid", 32'(o_v), 32'h0);
        @(negedge clk); clr(); rd_a = 5'd5; rf_a = 32'hF0;
        tick();
        check("t2_hist", o_a, 32'h22);
        check("t2_hist_hit", 32'(o_ha), 32'h1);
        @(negedge clk); clr(); rd_a = 5'd5; rf_a = 32'hF0;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
        tick();
        check("t2_wb_over_hist", o_a, 32'h11);
        check("t2_wb_hit", 32'(o_ha), 32'h0);
        @(negedge clk); clr(); rd_a = 5'd5; byp_a = 1'b1; sel_a = 2'd1;
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h66;
        tick();
        check("t2_bypass", o_a, 32'h33);
        @(negedge clk); clr(); rd_a = 5'd5; rd_b = 5'd5; rf_b = 32'h77;
        tick();
        check("t2_youngest", o_a, 32'h66);
        check("t2_hitB", 32'(o_hb), 32'h1);
        @(negedge clk); clr(); rd_a = 5'd1; rf_a = 32'h5A;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h44;
        tick();
        check("t2_r1_wb", o_a, 32'h5A);
        @(negedge clk); clr(); rd_a = 5'd1; rf_a = 32'h5A;
        tick();
        check("t2_r1_hist", o_a, 32'h5A);

        // T3 history depth
        @(negedge clk); clr(); issue = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'd1;
        @(negedge clk); wb_data = 32'd2;
        @(negedge clk); wb_addr = 5'd9; wb_data = 32'd3;
        @(negedge clk); clr(); rd_a = 5'd7; rf_a = 32'hAB;
        tick();
        check("t3_r7", o_a, 32'd2);
        @(negedge clk); clr(); issue = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'd4;
        @(negedge clk); clr(); rd_a = 5'd7; rf_a = 32'hAB;
        tick();
        check("t3_evict", o_a, 32'hAB);
        check("t3_evict_hit", 32'(o_ha), 32'h0);

        // T4 stall and flush
        @(negedge clk); clr(); rd_a = 5'd3; rf_a = 32'hA5;
        tick();
        check("t4_cap", o_a, 32'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); clr(); stall = 1'b1; rd_a = 5'd3; rf_a = 32'h11;
            wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
            tick();
            check("t4_hold", o_a, 32'hA5);
        end
        @(negedge clk); clr(); rd_a = 5'd3;
        tick();
        check("t4_release", o_a, 32'h77);
        check("t4_release_hit", 32'(o_ha), 32'h1);
        @(negedge clk); clr(); flush = 1'b1; rd_a = 5'd2; rf_a = 32'h9;
        tick();
        check("t4_flush_valid", 32'(o_v), 32'h0);
        check("t4_flush_hold", o_a, 32'h77);
        @(negedge clk); clr(); rd_a = 5'd2; rf_a = 32'h9;
        tick();
        @(negedge clk); clr(); flush = 1'b1; stall = 1'b1;
        tick();
        check("t4_flush_stall", 32'(o_v), 32'h0);

        // T5 immediate and RSUBI
        @(negedge clk); clr(); rd_a = 5'd12; rf_a = 32'd10;
        rd_b = 5'd13; rf_b = 32'h2B; imm = 32'd3;
        sel_imm = 1'b1; is_sub = 1'b1;
        tick();
        check("t5_A", o_a, 32'd3);
        check("t5_B", o_b, 32'd10);
        check("t5_store", o_s, 32'h2B);
        @(negedge clk); clr(); rd_a = 5'd12; rf_a = 32'd10;
        rd_b = 5'd13; rf_b = 32'h2B; imm = 32'd3; sel_imm = 1'b1;
        tick();
        check("t5_imm_B", o_b, 32'd3);
        @(negedge clk); clr(); rd_a = 5'd12; rf_a = 32'd10;
        rd_b = 5'd13; rf_b = 32'h2B; is_sub = 1'b1;
        tick();
        check("t5_sub_noswap", o_a, 32'd10);

`ifdef PE_BYPASS_NEIGHBOUR_EN
        // T6 neighbour select
        @(negedge clk); clr(); rd_a = 5'd12; rf_a = 32'd10; dsel = 3'b110;
        tick();
        check("t6_left_m4", o_a, 32'hBEEF);
        check("t6_port1", port1, 32'd10);
        @(negedge clk); clr(); rd_a = 5'd12; rf_a = 32'd10; dsel = 3'b111;
        tick();
        check("t6_base", o_a, 32'd10);
`endif

        @(negedge clk); clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
